mcycle_ctrl: RTL and testbench
==============================

// Module: mcycle_ctrl
//
// PURPOSE
// Sequences the multi-cycle execute resources (divider, multiplier, carry-less multiplier)
// flagged by the decoder's division / mult / bitc outputs. Accepts one op at a time from the
// execute stage and stalls the pipeline while the op is in flight. Starts and kills the
// selected unit. Holds the captured result until writeback accepts it.
//
// PARAMETERS
// MUL_LAT   3   fixed multiplier latency in cycles from mul_start to a valid mul_result; legal range >= 1
// XLEN      32  data width of results
//
// PORTS
// clock         in   1     system clock, rising edge
// reset         in   1     synchronous reset, active-high
// issue_valid   in   1     execute stage presents an op this cycle
// issue_div     in   1     op is a division/remainder (decoder division)
// issue_mul     in   1     op is a multiply (decoder mult)
// issue_clmul   in   1     op is a clmul/clmulh/clmulr (decoder bitc)
// issue_waddr   in   5     destination register of the op
// flush         in   1     pipeline flush (trap, mret, mispredict); aborts the in-flight op
// wb_ready      in   1     writeback accepts res_data this cycle
// div_done      in   1     divider result valid (1-cycle pulse)
// div_result    in   XLEN  divider result
// clmul_done    in   1     clmul result valid (1-cycle pulse)
// clmul_result  in   XLEN  clmul result
// mul_result    in   XLEN  multiplier result, valid MUL_LAT cycles after mul_start
// div_start     out  1     1-cycle start pulse to the divider
// mul_start     out  1     1-cycle start pulse to the multiplier
// clmul_start   out  1     1-cycle start pulse to the clmul unit
// div_kill      out  1     1-cycle abort pulse to the divider
// clmul_kill    out  1     1-cycle abort pulse to the clmul unit
// stall         out  1     hold the front-end and execute stage (combinational)
// busy_waddr    out  5     destination of the in-flight op; 0 when idle (hazard check)
// res_valid     out  1     result held for writeback
// res_data      out  XLEN  held result
// res_waddr     out  5     destination of the held result
// illegal       out  1     1-cycle pulse: issue carried more than one unit flag
//
// BEHAVIOUR
// - Reset: state IDLE. All registered outputs 0: starts, kills, res_valid, res_data, res_waddr, busy_waddr, illegal.
// - States: IDLE, RUN_DIV, RUN_MUL, RUN_CLMUL, DONE.
// - Accept condition: state IDLE & issue_valid & exactly one flag set & ~flush.
//   - On acceptance, latch issue_waddr and go to RUN_x next cycle.
//   - The matching x_start is high for exactly the first cycle of RUN_x.
// - Illegal issue: issue_valid with two or more flags -> illegal pulses next cycle, no start, state stays IDLE.
//   Zero flags with issue_valid -> ignored.
// - Stall: stall = (state != IDLE & ~(state == DONE & wb_ready)) | accept.
//   The accepting cycle already stalls.
// - RUN_MUL:
//   - Down-counter of width $clog2(MUL_LAT+1) is loaded with MUL_LAT on entry and decremented each cycle.
//   - When the count reaches 1, capture mul_result and go to DONE.
//   - Total: MUL_LAT+1 cycles from acceptance to res_valid.
// - RUN_DIV / RUN_CLMUL: wait for the matching done pulse. Capture the result and go to DONE next cycle.
//   No timeout.
// - DONE: res_valid = 1 and res_data/res_waddr stable until wb_ready; then IDLE the next cycle.
//   No new op is accepted in DONE, even if wb_ready is high; the next issue is accepted in IDLE.
// - Flush, any RUN state:
//   - Next state IDLE; busy_waddr cleared.
//   - div_kill/clmul_kill pulses 1 cycle for the active div/clmul unit.
//   - A multiply is simply discarded (pipeline unit, no kill).
// - Flush in DONE: result dropped, res_valid 0 next cycle.
// - Flush in the same cycle as done: flush wins, result discarded, kill still pulsed.
// - Flush together with issue: no acceptance.
// - done pulses arriving in IDLE, DONE or the wrong RUN state are ignored.
// - Reset mid-operation: return to IDLE with no kill pulse; units are reset by the same reset.
// - busy_waddr = latched waddr in RUN_x and DONE, else 0.
//
// STRUCTURE
// - Shared package (constants):
//   - mcycle_state_type enum (IDLE, RUN_DIV, RUN_MUL, RUN_CLMUL, DONE).
//   - MUL_LAT default constant.
// - Shared package (wires):
//   - mcycle_ctrl_in_type / mcycle_ctrl_out_type structs grouping issue, unit and result signals.
// - Single module with two always blocks: combinational next-state/outputs, registered state.
//   No sub-module.
//
// TESTING
// - MUL, MUL_LAT=3: issue_mul, waddr=5 at cycle 0 -> mul_start at cycle 1; mul_result=0x0000_0F0F at cycle 4
//   -> res_valid at cycle 4, res_data=0x0000_0F0F, res_waddr=5; stall 0 after the wb_ready cycle.
// - DIV, variable latency: issue_div, div_done at cycle 20 with 0xFFFF_FFFF -> res_valid cycle 21;
//   wb_ready held low 3 cycles -> data stable; stall high throughout.
// - Flush mid-div: flush at cycle 5 of RUN_DIV -> div_kill pulse at cycle 6, state IDLE, busy_waddr=0;
//   a later div_done is ignored with res_valid held at 0.
// - Flush with clmul_done in the same cycle -> clmul_kill pulses, res_valid stays 0.
// - Illegal issue: issue_div & issue_mul -> illegal=1 for 1 cycle, no start pulses, stall 0.
// - Back-to-back: wb_ready in DONE with the next issue_mul present -> accepted the cycle after return to IDLE;
//   reset asserted during RUN_MUL -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mcycle_ctrl_pkg.sv
// Shared types and defaults for the multi-cycle execute sequencer.
package mcycle_ctrl_pkg;

  localparam int MUL_LAT_DEF = 3;
  localparam int XLEN_DEF    = 32;

  typedef enum logic [2:0] {
    IDLE,
    RUN_DIV,
    RUN_MUL,
    RUN_CLMUL,
    DONE
  } mcycle_state_type;

  // Data buses stay outside these structs so XLEN remains a free parameter.
  typedef struct packed {
    logic       valid;
    logic       div;
    logic       mul;
    logic       clmul;
    logic [4:0] waddr;
    logic       flush;
    logic       wb_ready;
    logic       div_done;
    logic       clmul_done;
  } mcycle_ctrl_in_type;

  typedef struct packed {
    logic div_start;
    logic mul_start;
    logic clmul_start;
    logic div_kill;
    logic clmul_kill;
    logic illegal;
  } mcycle_ctrl_out_type;

  function automatic logic [1:0] flag_count(input logic a, input logic b, input logic c);
    return {1'b0, a} + {1'b0, b} + {1'b0, c};
  endfunction

endpackage

// File: rtl/mcycle_ctrl_if.sv
// Issue, unit and writeback signals between the execute stage, the
// multi-cycle units and the sequencer.
interface mcycle_ctrl_if #(
  parameter int XLEN = 32
);
  logic            issue_valid;
  logic            issue_div;
  logic            issue_mul;
  logic            issue_clmul;
  logic [4:0]      issue_waddr;
  logic            flush;
  logic            wb_ready;
  logic            div_done;
  logic [XLEN-1:0] div_result;
  logic            clmul_done;
  logic [XLEN-1:0] clmul_result;
  logic [XLEN-1:0] mul_result;
  logic            div_start;
  logic            mul_start;
  logic            clmul_start;
  logic            div_kill;
  logic            clmul_kill;
  logic            stall;
  logic [4:0]      busy_waddr;
  logic            res_valid;
  logic [XLEN-1:0] res_data;
  logic [4:0]      res_waddr;
  logic            illegal;

  modport master (
    output issue_valid, issue_div, issue_mul, issue_clmul, issue_waddr,
           flush, wb_ready, div_done, div_result, clmul_done, clmul_result, mul_result,
    input  div_start, mul_start, clmul_start, div_kill, clmul_kill,
           stall, busy_waddr, res_valid, res_data, res_waddr, illegal
  );

  modport slave (
    input  issue_valid, issue_div, issue_mul, issue_clmul, issue_waddr,
           flush, wb_ready, div_done, div_result, clmul_done, clmul_result, mul_result,
    output div_start, mul_start, clmul_start, div_kill, clmul_kill,
           stall, busy_waddr, res_valid, res_data, res_waddr, illegal
  );
endinterface

// File: rtl/mcycle_ctrl.sv
// Sequences one divide/multiply/clmul op at a time, stalls the pipe while it runs
// and holds the result until writeback takes it; multiply done after MUL_LAT+1 cycles.
module mcycle_ctrl
  import mcycle_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int XLEN    = XLEN_DEF
) (
  input logic        clock,
  input logic        reset,
  mcycle_ctrl_if.slave bus
);

  localparam int            CW       = $clog2(MUL_LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LAT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  mcycle_ctrl_in_type  in_s;
  mcycle_ctrl_out_type ctl_q, ctl_d;
  mcycle_state_type    state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4:0]          waddr_q, waddr_d;
  logic [4:0]          busy_q, busy_d;
  logic [4:0]          res_waddr_q, res_waddr_d;
  logic [XLEN-1:0]     res_data_q, res_data_d;
  logic                res_valid_q;
  logic [1:0]          n_flags;
  logic                accept;
  logic                stall_c;

  assign in_s = '{valid:      bus.issue_valid,
                  div:        bus.issue_div,
                  mul:        bus.issue_mul,
                  clmul:      bus.issue_clmul,
                  waddr:      bus.issue_waddr,
                  flush:      bus.flush,
                  wb_ready:   bus.wb_ready,
                  div_done:   bus.div_done,
                  clmul_done: bus.clmul_done};

  assign n_flags = flag_count(in_s.div, in_s.mul, in_s.clmul);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    waddr_d     = waddr_q;
    res_data_d  = res_data_q;
    res_waddr_d = res_waddr_q;
    ctl_d       = '0;
    accept      = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_s.valid && !in_s.flush && n_flags == 2'd1) begin
          accept            = 1'b1;
          waddr_d           = in_s.waddr;
          cnt_d             = CNT_LOAD;
          ctl_d.div_start   = in_s.div;
          ctl_d.mul_start   = in_s.mul;
          ctl_d.clmul_start = in_s.clmul;
          state_d           = in_s.div ? RUN_DIV : (in_s.mul ? RUN_MUL : RUN_CLMUL);
        end else if (in_s.valid && n_flags >= 2'd2) begin
          ctl_d.illegal = 1'b1;
        end
      end
      RUN_DIV: begin
        // flush beats a same-cycle done: the result is dropped and the unit still killed
        if (in_s.flush) begin
          ctl_d.div_kill = 1'b1;
          state_d        = IDLE;
        end else if (in_s.div_done) begin
          res_data_d  = bus.div_result;
          res_waddr_d = waddr_q;
          state_d     = DONE;
        end
      end
      RUN_MUL: begin
        if (in_s.flush) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_ONE) begin
          res_data_d  = bus.mul_result;
          res_waddr_d = waddr_q;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RUN_CLMUL: begin
        if (in_s.flush) begin
          ctl_d.clmul_kill = 1'b1;
          state_d          = IDLE;
        end else if (in_s.clmul_done) begin
          res_data_d  = bus.clmul_result;
          res_waddr_d = waddr_q;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (in_s.flush || in_s.wb_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d == IDLE) ? 5'd0 : waddr_d;
    stall_c = ((state_q != IDLE) && !(state_q == DONE && in_s.wb_ready)) || accept;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      waddr_q     <= '0;
      busy_q      <= '0;
      res_waddr_q <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      ctl_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      waddr_q     <= waddr_d;
      busy_q      <= busy_d;
      res_waddr_q <= res_waddr_d;
      res_data_q  <= res_data_d;
      res_valid_q <= (state_d == DONE);
      ctl_q       <= ctl_d;
    end
  end

  assign bus.div_start   = ctl_q.div_start;
  assign bus.mul_start   = ctl_q.mul_start;
  assign bus.clmul_start = ctl_q.clmul_start;
  assign bus.div_kill    = ctl_q.div_kill;
  assign bus.clmul_kill  = ctl_q.clmul_kill;
  assign bus.illegal     = ctl_q.illegal;
  assign bus.stall       = stall_c;
  assign bus.busy_waddr  = busy_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_waddr   = res_waddr_q;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Bench for mcycle_ctrl: idle-issue vector table, directed multi-cycle sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mcycle_ctrl;

  localparam int MUL_LAT = 3;
  localparam int XLEN    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mcycle_ctrl_if #(.XLEN(XLEN)) ifc ();

  mcycle_ctrl #(.MUL_LAT(MUL_LAT), .XLEN(XLEN)) dut (
    .clock(clk),
    .reset(rst),
    .bus  (ifc.slave)
  );

  typedef struct {
    logic v, d, m, c, f;
    logic stall;
    logic [3:0] pulses;  // {div_start, mul_start, clmul_start, illegal}
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {div_start, mul_start, clmul_start, div_kill, clmul_kill, illegal}
  function automatic logic [5:0] pulses();
    return {ifc.div_start, ifc.mul_start, ifc.clmul_start, ifc.div_kill, ifc.clmul_kill, ifc.illegal};
  endfunction

  task automatic clear_inputs();
    ifc.issue_valid  = 1'b0;
    ifc.issue_div    = 1'b0;
    ifc.issue_mul    = 1'b0;
    ifc.issue_clmul  = 1'b0;
    ifc.issue_waddr  = 5'd0;
    ifc.flush        = 1'b0;
    ifc.wb_ready     = 1'b0;
    ifc.div_done     = 1'b0;
    ifc.div_result   = '0;
    ifc.clmul_done   = 1'b0;
    ifc.clmul_result = '0;
    ifc.mul_result   = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic issue(input logic d, input logic m, input logic c, input logic [4:0] wa);
    ifc.issue_valid = 1'b1;
    ifc.issue_div   = d;
    ifc.issue_mul   = m;
    ifc.issue_clmul = c;
    ifc.issue_waddr = wa;
  endtask

  // Reference model state: op in flight, result held, cycles since acceptance.
  logic            m_busy, m_hold;
  int              m_kind;  // 0 div, 1 mul, 2 clmul
  int              m_age;
  logic [4:0]      m_waddr;
  logic [XLEN-1:0] m_data;
  logic [5:0]      e_pulses;

  task automatic model_step(output logic exp_stall);
    logic [1:0] nf;
    logic       idle, acc;
    nf   = {1'b0, ifc.issue_div} + {1'b0, ifc.issue_mul} + {1'b0, ifc.issue_clmul};
    idle = !m_busy && !m_hold;
    acc  = idle && ifc.issue_valid && nf == 2'd1 && !ifc.flush;
    exp_stall = m_busy || (m_hold && !ifc.wb_ready) || acc;
    e_pulses = '0;
    if (rst) begin
      m_busy = 1'b0;
      m_hold = 1'b0;
    end else if (m_busy) begin
      if (ifc.flush) begin
        if (m_kind == 0) e_pulses[2] = 1'b1;
        if (m_kind == 2) e_pulses[1] = 1'b1;
        m_busy = 1'b0;
      end else if (m_kind == 1 && m_age == MUL_LAT) begin
        m_data = ifc.mul_result; m_hold = 1'b1; m_busy = 1'b0;
      end else if (m_kind == 0 && ifc.div_done) begin
        m_data = ifc.div_result; m_hold = 1'b1; m_busy = 1'b0;
      end else if (m_kind == 2 && ifc.clmul_done) begin
        m_data = ifc.clmul_result; m_hold = 1'b1; m_busy = 1'b0;
      end
      m_age++;
    end else if (m_hold) begin
      if (ifc.flush || ifc.wb_ready) m_hold = 1'b0;
    end else if (acc) begin
      m_busy  = 1'b1;
      m_age   = 1;
      m_waddr = ifc.issue_waddr;
      m_kind  = ifc.issue_div ? 0 : (ifc.issue_mul ? 1 : 2);
      e_pulses[5-m_kind] = 1'b1;
    end else if (ifc.issue_valid && nf >= 2'd2) begin
      e_pulses[0] = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] fl;
    logic       es;
    int         bad;

    tbl[0] = '{0,0,0,0,0, 0, 4'b0000};
    tbl[1] = '{1,1,0,0,0, 1, 4'b1000};
    tbl[2] = '{1,0,1,0,0, 1, 4'b0100};
    tbl[3] = '{1,0,0,1,0, 1, 4'b0010};
    tbl[4] = '{1,0,0,0,0, 0, 4'b0000};
    tbl[5] = '{1,1,1,0,0, 0, 4'b0001};
    tbl[6] = '{1,1,1,1,0, 0, 4'b0001};
    tbl[7] = '{1,1,0,0,1, 0, 4'b0000};
    tbl[8] = '{0,0,1,0,0, 0, 4'b0000};
    tbl[9] = '{1,0,1,1,1, 0, 4'b0001};

    clear_inputs();
    do_reset();
    chk("reset_outputs", {pulses(), ifc.res_valid, ifc.busy_waddr, ifc.res_waddr, ifc.res_data}, 64'd0);
    chk("reset_stall", ifc.stall, 1'b0);

    foreach (tbl[i]) begin
      do_reset();
      issue(tbl[i].d, tbl[i].m, tbl[i].c, 5'd11);
      ifc.issue_valid = tbl[i].v;
      ifc.flush       = tbl[i].f;
      #1 chk($sformatf("vec%0d_stall", i), ifc.stall, tbl[i].stall);
      @(negedge clk);
      clear_inputs();
      chk($sformatf("vec%0d_pulses", i),
          {ifc.div_start, ifc.mul_start, ifc.clmul_start, ifc.illegal}, tbl[i].pulses);
    end

    // multiply: result valid MUL_LAT+1 cycles after acceptance
    do_reset();
    issue(0, 1, 0, 5'd5);
    ifc.mul_result = 32'h0000_0F0F;
    #1 chk("mul_c0_stall", ifc.stall, 1'b1);
    @(negedge clk); ifc.issue_valid = 1'b0;
    chk("mul_c1_start", pulses(), 6'b010000);
    chk("mul_c1_busy", ifc.busy_waddr, 5'd5);
    @(negedge clk); chk("mul_c2", {pulses(), ifc.res_valid}, 7'd0);
    @(negedge clk); chk("mul_c3_rv", ifc.res_valid, 1'b0);
    @(negedge clk);
    chk("mul_c4_res", {ifc.res_valid, ifc.res_waddr, ifc.res_data}, {1'b1, 5'd5, 32'h0000_0F0F});
    #1 chk("mul_c4_stall", ifc.stall, 1'b1);
    ifc.wb_ready = 1'b1;
    #1 chk("mul_c4_stall_wb", ifc.stall, 1'b0);
    @(negedge clk); ifc.wb_ready = 1'b0;
    chk("mul_c5_idle", {ifc.res_valid, ifc.busy_waddr}, 6'd0);
    #1 chk("mul_c5_stall", ifc.stall, 1'b0);

    // divide with a long latency and a slow writeback
    do_reset();
    issue(1, 0, 0, 5'd9);
    bad = 0;
    for (int c = 1; c < 20; c++) begin
      @(negedge clk); ifc.issue_valid = 1'b0;
      #1 if (!ifc.stall || ifc.res_valid) bad++;
    end
    chk("div_wait_cycles", bad, 0);
    @(negedge clk);
    ifc.div_done = 1'b1; ifc.div_result = 32'hFFFF_FFFF;
    @(negedge clk);
    ifc.div_done = 1'b0; ifc.div_result = 32'h1234_5678;
    for (int c = 21; c < 24; c++) begin
      #1 chk($sformatf("div_c%0d_hold", c), {ifc.res_valid, ifc.res_waddr, ifc.res_data, ifc.stall},
             {1'b1, 5'd9, 32'hFFFF_FFFF, 1'b1});
      @(negedge clk);
    end
    ifc.wb_ready = 1'b1;
    #1 chk("div_c24", {ifc.res_valid, ifc.stall}, 2'b10);
    @(negedge clk); ifc.wb_ready = 1'b0;
    chk("div_c25_rv", ifc.res_valid, 1'b0);

    // flush mid-divide, late done ignored
    do_reset();
    issue(1, 0, 0, 5'd12);
    @(negedge clk); ifc.issue_valid = 1'b0;
    repeat (4) @(negedge clk);
    ifc.flush = 1'b1;
    @(negedge clk); ifc.flush = 1'b0;
    chk("flushdiv_kill", {pulses(), ifc.busy_waddr, ifc.res_valid}, {6'b000100, 5'd0, 1'b0});
    #1 chk("flushdiv_stall", ifc.stall, 1'b0);
    @(negedge clk); chk("flushdiv_kill_end", pulses(), 6'd0);
    @(negedge clk); ifc.div_done = 1'b1; ifc.div_result = 32'hABCD;
    @(negedge clk); ifc.div_done = 1'b0;
    chk("flushdiv_late_done", {ifc.res_valid, ifc.busy_waddr}, 6'd0);

    // flush together with clmul_done
    do_reset();
    issue(0, 0, 1, 5'd3);
    @(negedge clk); ifc.issue_valid = 1'b0;
    chk("clmul_start", pulses(), 6'b001000);
    @(negedge clk);
    @(negedge clk); ifc.clmul_done = 1'b1; ifc.clmul_result = 32'h55; ifc.flush = 1'b1;
    @(negedge clk); ifc.clmul_done = 1'b0; ifc.flush = 1'b0;
    chk("clmul_flush_kill", {pulses(), ifc.res_valid}, {6'b000010, 1'b0});
    @(negedge clk); chk("clmul_flush_after", {pulses(), ifc.res_valid}, 7'd0);

    // back-to-back issue, then reset during RUN_MUL
    do_reset();
    issue(0, 1, 0, 5'd4);
    ifc.mul_result = 32'h77;
    @(negedge clk); ifc.issue_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_done", ifc.res_valid, 1'b1);
    ifc.wb_ready = 1'b1;
    issue(0, 1, 0, 5'd7);
    #1 chk("b2b_no_accept_in_done", ifc.stall, 1'b0);
    @(negedge clk); ifc.wb_ready = 1'b0;
    chk("b2b_idle_rv", ifc.res_valid, 1'b0);
    #1 chk("b2b_accept_stall", ifc.stall, 1'b1);
    @(negedge clk); ifc.issue_valid = 1'b0;
    chk("b2b_start", {pulses(), ifc.busy_waddr}, {6'b010000, 5'd7});
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_mid_mul", {pulses(), ifc.res_valid, ifc.busy_waddr, ifc.res_waddr, ifc.res_data}, 64'd0);
    #1 chk("rst_mid_mul_stall", ifc.stall, 1'b0);

    // randomized traffic against the reference model
    do_reset();
    m_busy = 1'b0; m_hold = 1'b0; m_kind = 0; m_age = 0; m_waddr = '0; m_data = '0;
    e_pulses = '0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      chk("rnd_pulses", pulses(), e_pulses);
      chk("rnd_res_valid", ifc.res_valid, m_hold);
      chk("rnd_busy_waddr", ifc.busy_waddr, (m_busy || m_hold) ? m_waddr : 5'd0);
      if (m_hold) chk("rnd_res", {ifc.res_waddr, ifc.res_data}, {m_waddr, m_data});
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) < 8) fl = 3'b001 << $urandom_range(0, 2);
      else fl = 3'($urandom_range(0, 7));
      issue(fl[2], fl[1], fl[0], 5'($urandom_range(0, 31)));
      ifc.issue_valid  = ($urandom_range(0, 2) == 0);
      ifc.flush        = ($urandom_range(0, 19) == 0);
      ifc.wb_ready     = ($urandom_range(0, 1) == 1);
      ifc.div_done     = ($urandom_range(0, 9) == 0);
      ifc.clmul_done   = ($urandom_range(0, 7) == 0);
      ifc.div_result   = $urandom;
      ifc.clmul_result = $urandom;
      ifc.mul_result   = $urandom;
      #1;
      model_step(es);
      chk("rnd_stall", ifc.stall, es);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
